// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, writeback request record and arbiter source encoding
package wb_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int AW = $clog2(NUM_REGS);
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
  typedef enum logic {GNT_ALU, GNT_LSU} wb_src_e;
endpackage

// File: rtl/wb_if.sv
// wb_if: decode/ALU/LSU/register-file signals of the writeback unit; WB_BYPASS_EN adds forwarding data
interface wb_if;
  import wb_pkg::*;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic            wb_err;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;
`endif
  modport slave (
    input  issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    output rf_we, rf_rd_addr, rf_rd_data, wb_err
`ifdef WB_BYPASS_EN
    , output rs1_fwd_data, rs2_fwd_data
`endif
  );
  modport master (
    output issue_valid, issue_rd, rs1_addr, rs2_addr,
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs1_busy, rs2_busy, alu_ready, lsu_ready,
    input  rf_we, rf_rd_addr, rf_rd_data, wb_err
`ifdef WB_BYPASS_EN
    , input rs1_fwd_data, rs2_fwd_data
`endif
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: 2-way round-robin, gnt[0]=ALU gnt[1]=LSU, last_grant moves only on conflict
module wb_rr_arbiter
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  wb_src_e last_grant;
  always_comb begin
    gnt[1] = req[1] && (!req[0] || last_grant == GNT_ALU);
    gnt[0] = req[0] && !gnt[1];
  end
  always_ff @(posedge clk) begin
    if (rst) last_grant <= GNT_ALU;
    else if (&req) last_grant <= gnt[1] ? GNT_LSU : GNT_ALU;
  end
endmodule

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: arbitrated RF writeback with busy scoreboard; WB_BYPASS_EN forwards the RF write
module wb_writeback_unit
  import wb_pkg::*;
(
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  logic [NUM_REGS-1:0] busy, busy_n, set_v, clr_v;
  logic [1:0] gnt;
  logic acc;
  wb_req_t req;
  wb_rr_arbiter u_arb (
    .clk(clk),
    .rst(rst),
    .req({bus.lsu_valid, bus.alu_valid}),
    .gnt(gnt)
  );
  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];
  assign acc = |gnt;
  assign req = gnt[1] ? {bus.lsu_rd, bus.lsu_data} : {bus.alu_rd, bus.alu_data};
  assign bus.issue_ready = !busy[bus.issue_rd];
  // set is applied after clear so a same-edge reissue keeps the register pending
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[bus.issue_rd] = bus.issue_valid && bus.issue_ready;
    clr_v[bus.rf_rd_addr] = bus.rf_we;
    busy_n = (busy & ~clr_v) | set_v;
    busy_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      bus.rf_we <= 1'b0;
      bus.rf_rd_addr <= '0;
      bus.rf_rd_data <= '0;
      bus.wb_err <= 1'b0;
    end else begin
      busy <= busy_n;
      bus.rf_we <= acc && req.rd != '0;
      if (acc) begin
        bus.rf_rd_addr <= req.rd;
        bus.rf_rd_data <= req.data;
      end
      if (acc && req.rd != '0 && !busy[req.rd]) bus.wb_err <= 1'b1;
    end
  end
`ifdef WB_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = bus.rf_we && bus.rf_rd_addr == bus.rs1_addr && bus.rs1_addr != '0;
  assign hit2 = bus.rf_we && bus.rf_rd_addr == bus.rs2_addr && bus.rs2_addr != '0;
  assign bus.rs1_busy = busy[bus.rs1_addr] && !hit1;
  assign bus.rs2_busy = busy[bus.rs2_addr] && !hit2;
  assign bus.rs1_fwd_data = hit1 ? bus.rf_rd_data : '0;
  assign bus.rs2_fwd_data = hit2 ? bus.rf_rd_data : '0;
`else
  assign bus.rs1_busy = busy[bus.rs1_addr];
  assign bus.rs2_busy = busy[bus.rs2_addr];
`endif
endmodule
